// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: mode encoding and default prescale ratio.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    localparam int unsigned CLK_DIV_DEFAULT = 100000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic [1:0] ST_LAP  = 2'd3;

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divides the clock by CLK_DIV while enabled, emitting a one-cycle registered tick on wrap.
module tick_prescaler #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CNT_W   = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (clr) begin
                r_cnt <= '0;
            end else if (en) begin
                if (r_cnt == CntMax) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign tick  = r_tick;
    assign count = r_cnt;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM: decodes button pulses, issues clear/lap strobes and gates the prescaler.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_edge,
    input  logic       lap_edge,
    input  logic       clr_edge,
    output logic       tick,
    output logic       count_clr,
    output logic       lap_capture,
    output logic       disp_hold,
    output logic       running,
    output logic [1:0] state
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic             r_count_clr;
    logic             r_lap_capture;
    logic             w_clr_d;
    logic             w_lap_d;
    logic             w_run_d;
    logic             w_pre_clr;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt;

    // Priority clr > ss > lap, applied only among events legal in the current state.
    always_comb begin
        w_state_d = r_state;
        w_clr_d   = 1'b0;
        w_lap_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_edge) begin
                    w_clr_d = 1'b1;
                end else if (ss_edge) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ss_edge) begin
                    w_state_d = ST_STOP;
                end else if (lap_edge) begin
                    w_state_d = ST_LAP;
                    w_lap_d   = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_edge) begin
                    w_state_d = ST_STOP;
                end else if (lap_edge) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (clr_edge) begin
                    w_state_d = ST_IDLE;
                    w_clr_d   = 1'b1;
                end else if (ss_edge) begin
                    w_state_d = ST_RUN;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_count_clr   <= 1'b0;
            r_lap_capture <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_count_clr   <= w_clr_d;
            r_lap_capture <= w_lap_d;
        end
    end

    // Prescaler follows the next state so its registered tick lines up with running=1.
    assign w_run_d   = (w_state_d == ST_RUN) || (w_state_d == ST_LAP);
    assign w_pre_clr = (w_state_d == ST_IDLE);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (w_run_d),
        .clr   (w_pre_clr),
        .tick  (w_tick),
        .count (w_cnt)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (w_cnt <= CNT_W'(CLK_DIV - 1));
            assert (!w_tick || running);
        end
    end

    assign tick        = w_tick;
    assign count_clr   = r_count_clr;
    assign lap_capture = r_lap_capture;
    assign state       = r_state;
    assign running     = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign disp_hold   = (r_state == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4: vector table plus reset corner sequences.
module tb_stopwatch_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int NVEC = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_edge;
    logic       lap_edge;
    logic       clr_edge;
    logic       tick;
    logic       count_clr;
    logic       lap_capture;
    logic       disp_hold;
    logic       running;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // {ss, lap, clr} applied for one cycle; exp = {tick, count_clr, lap_capture, disp_hold,
    // running, state} seen just after the edge that samples them.
    typedef struct packed {
        logic       ss;
        logic       lap;
        logic       clr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    stopwatch_ctrl #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ss_edge     (ss_edge),
        .lap_edge    (lap_edge),
        .clr_edge    (clr_edge),
        .tick        (tick),
        .count_clr   (count_clr),
        .lap_capture (lap_capture),
        .disp_hold   (disp_hold),
        .running     (running),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic l, input logic c, input logic t,
                                input logic cc, input logic lc, input logic h, input logic r,
                                input logic [1:0] st);
        vec_t v;
        v.ss  = s;
        v.lap = l;
        v.clr = c;
        v.exp = {t, cc, lc, h, r, st};
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {tick, count_clr, lap_capture, disp_hold, running, state};
    endfunction

    task automatic check(input string name, input int idx, input logic [6:0] exp);
        logic [6:0] got;
        got = outs();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got tick,clr,cap,hold,run,st=%b want %b", name, idx, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic l, input logic c);
        @(negedge clk);
        ss_edge  = s;
        lap_edge = l;
        clr_edge = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            ss lap clr  tk cc lc hd rn st
        vecs[0]  = mk(1, 0, 0,   0, 0, 0, 0, 1, 2'd1); // start, cnt 1
        vecs[1]  = mk(0, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[2]  = mk(0, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[3]  = mk(0, 0, 0,   1, 0, 0, 0, 1, 2'd1); // 4th running cycle
        vecs[4]  = mk(0, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[5]  = mk(0, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[6]  = mk(0, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[7]  = mk(0, 0, 0,   1, 0, 0, 0, 1, 2'd1); // 8th
        vecs[8]  = mk(0, 1, 0,   0, 0, 1, 1, 1, 2'd3); // lap capture
        vecs[9]  = mk(0, 0, 0,   0, 0, 0, 1, 1, 2'd3);
        vecs[10] = mk(0, 0, 1,   0, 0, 0, 1, 1, 2'd3); // clr ignored in LAP
        vecs[11] = mk(0, 0, 0,   1, 0, 0, 1, 1, 2'd3); // 12th, cadence kept
        vecs[12] = mk(0, 1, 0,   0, 0, 0, 0, 1, 2'd1); // release hold
        vecs[13] = mk(0, 0, 1,   0, 0, 0, 0, 1, 2'd1); // clr ignored in RUN, cnt 2
        vecs[14] = mk(1, 0, 0,   0, 0, 0, 0, 0, 2'd2); // stop, cnt holds 2
        vecs[15] = mk(0, 0, 0,   0, 0, 0, 0, 0, 2'd2);
        vecs[16] = mk(0, 0, 0,   0, 0, 0, 0, 0, 2'd2);
        vecs[17] = mk(0, 1, 0,   0, 0, 0, 0, 0, 2'd2); // lap ignored in STOP
        vecs[18] = mk(0, 0, 0,   0, 0, 0, 0, 0, 2'd2);
        vecs[19] = mk(1, 0, 0,   0, 0, 0, 0, 1, 2'd1); // resume, cnt 3
        vecs[20] = mk(0, 0, 0,   1, 0, 0, 0, 1, 2'd1); // partial tick completes
        vecs[21] = mk(1, 1, 0,   0, 0, 0, 0, 0, 2'd2); // ss beats lap
        vecs[22] = mk(1, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[23] = mk(0, 1, 0,   0, 0, 1, 1, 1, 2'd3);
        vecs[24] = mk(1, 0, 0,   0, 0, 0, 0, 0, 2'd2); // ss in LAP -> STOP
        vecs[25] = mk(1, 0, 1,   0, 1, 0, 0, 0, 2'd0); // clr beats ss
        vecs[26] = mk(0, 0, 0,   0, 0, 0, 0, 0, 2'd0);
        vecs[27] = mk(0, 0, 1,   0, 1, 0, 0, 0, 2'd0); // clr in IDLE
        vecs[28] = mk(0, 1, 0,   0, 0, 0, 0, 0, 2'd0); // lap ignored in IDLE
        vecs[29] = mk(1, 1, 0,   0, 0, 0, 0, 1, 2'd1); // start from cleared cnt
        vecs[30] = mk(1, 0, 0,   0, 0, 0, 0, 0, 2'd2); // back-to-back ss
        vecs[31] = mk(1, 0, 0,   0, 0, 0, 0, 1, 2'd1);
        vecs[32] = mk(0, 0, 0,   0, 0, 0, 0, 1, 2'd1);

        ss_edge  = 1'b0;
        lap_edge = 1'b0;
        clr_edge = 1'b0;
        rst      = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", i, 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle", i, 7'b0);
        end

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].ss, vecs[i].lap, vecs[i].clr);
            check("vec", i, vecs[i].exp);
        end

        // Cleared prescaler: 4th running cycle since vec 29 (vecs 29, 31, 32, this one).
        step(1'b0, 1'b0, 1'b0);
        check("post_clr_tick", 0, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});

        // Mid-run reset while in LAP, between ticks.
        step(1'b0, 1'b1, 1'b0);
        check("pre_rst_lap", 0, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3});
        step(1'b0, 1'b0, 1'b0);
        check("pre_rst_lap", 1, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 0, 7'b0);
        @(posedge clk);
        #1;
        check("async_rst", 1, 7'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("post_rst_idle", 0, 7'b0);

        step(1'b1, 1'b0, 1'b0);
        check("restart", 0, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("restart", i, {(i == 3), 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        end
        step(1'b0, 1'b0, 1'b0);
        check("restart", 4, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch. Consumes the single-cycle edge pulses produced by the synchronizer/edge-detector stage for the start/stop, lap and clear buttons. Runs the stopwatch mode FSM, generates the prescaled count-enable tick for the time-counter datapath, and issues the clear and lap-capture strobes to the counter and display registers.

## Interface
- CLK_DIV, default 100000, clock cycles per count tick; must be ≥ 2.
- CNT_W, default $clog2(CLK_DIV), prescaler counter width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, input, 1, system clock.
  - rst, input, 1, asynchronous active-high reset.
- Button events:
  - ss_edge, input, 1, start/stop press pulse, one cycle wide.
  - lap_edge, input, 1, lap press pulse, one cycle wide.
  - clr_edge, input, 1, clear press pulse, one cycle wide.
- Datapath controls:
  - tick, output, 1, count-enable pulse to the time counter, one cycle wide.
  - count_clr, output, 1, synchronous clear strobe to the time counter and prescaler, one cycle wide.
  - lap_capture, output, 1, load strobe for the display hold register, one cycle wide.
- Status:
  - disp_hold, output, 1, display shows held lap value.
  - running, output, 1, stopwatch counting.
  - state, output, 2, current FSM state (state_t encoding).

## Operation
- FSM states: IDLE=0, RUN=1, STOP=2, LAP=3.
- Event priority when events coincide in one cycle: clr_edge > ss_edge > lap_edge. Only the highest-priority legal event acts; the rest are dropped.
- IDLE:
  - ss → RUN.
  - clr → IDLE, with a count_clr pulse.
  - lap is ignored.
- RUN:
  - ss → STOP.
  - lap → LAP, with a lap_capture pulse.
  - clr is ignored.
- LAP (counting continues, display frozen):
  - lap → RUN (releases the hold).
  - ss → STOP (releases the hold).
  - clr is ignored.
- STOP:
  - ss → RUN.
  - clr → IDLE, with a count_clr pulse.
  - lap is ignored.
- Illegal or unencoded state → IDLE.
- Moore-decoded outputs:
  - running = (state==RUN || state==LAP).
  - disp_hold = (state==LAP).
- Prescaler (range 0..CLK_DIV-1):
  - Increments while running.
  - Wraps CLK_DIV-1 → 0 and asserts tick on the wrap.
  - Holds its value in STOP, so a resume keeps the partial tick.
  - Forced to 0 in IDLE and on count_clr.
- tick is never asserted while running=0.
- Reset: state=IDLE, prescaler=0, and every output is 0 (tick, count_clr, lap_capture, disp_hold, running, state=2'b00).

## Timing
- Event sampled at edge k.
  - New state is visible after edge k.
  - count_clr or lap_capture is asserted for the cycle following edge k, coincident with the new state.
  - Both strobes are registered.
- Prescaler starts counting in the first cycle with running=1.
  - First tick after RUN entry from IDLE is the CLK_DIV-th running cycle.
  - tick is registered and high for exactly one cycle per CLK_DIV running cycles.
- RUN→LAP→RUN does not disturb the prescaler phase. The tick cadence is unbroken.
- Back-to-back events on consecutive cycles are each processed. There is no lockout.
- Reset asserted mid-operation:
  - All outputs drop to 0 asynchronously.
  - After release, the block is in IDLE. The first edge after release is sampled normally.
- Event pulses longer than one cycle are treated as repeated events. Upstream guarantees single-cycle pulses.

## Structure
- stopwatch_pkg holds the state_t enum (IDLE, RUN, STOP, LAP; 2-bit) and the default CLK_DIV constant, shared with the time counter and display blocks.
- One sub-module, tick_prescaler. Parameters: CLK_DIV. Inputs: clk, rst, en, clr. Outputs: tick and the counter value.
- The FSM with strobe generation stays in stopwatch_ctrl.

## Test plan
All scenarios use CLK_DIV=4.
- Reset then idle: rst high for 3 cycles, then low for 10 cycles with no events → all outputs stay 0 and state=0.
- Start and count: ss pulse at cycle 0 → running=1 from cycle 1; tick high at cycles 4, 8 and 12 only.
- Pause and resume phase: start, then ss after 2 running cycles, wait 5 cycles, ss again → no tick during STOP; first tick arrives 2 running cycles after resume.
- Lap:
  - In RUN, lap pulse → lap_capture high for 1 cycle, disp_hold=1 and state=3, with ticks uninterrupted.
  - Second lap pulse → disp_hold=0 and state=1.
- Clear priority:
  - In STOP, clr and ss in the same cycle → state=IDLE, count_clr high for 1 cycle, prescaler=0.
  - In RUN, clr pulse → no effect.
- Mid-run reset: assert rst between ticks while in LAP → outputs go 0 immediately; after release the next ss restarts with a full CLK_DIV tick delay.
